// File: rtl/auto_setting_param_if.sv
// Keypad/time-register bus for the time-setting engine: controls and current time in,
// working time and status out.
interface auto_setting_param_if;
  logic       en;
  logic [9:0] keypad;
  logic       sharp;
  logic [3:0] oHour10, oHour1, oMinute10, oMinute1, oSecond10, oSecond1;
  logic [3:0] hour10, hour1, minute10, minute1, second10, second1;
  logic       complete;
  logic       busy;
  logic       clamped;

  modport master (
    output en, keypad, sharp,
    output oHour10, oHour1, oMinute10, oMinute1, oSecond10, oSecond1,
    input  hour10, hour1, minute10, minute1, second10, second1,
    input  complete, busy, clamped
  );

  modport slave (
    input  en, keypad, sharp,
    input  oHour10, oHour1, oMinute10, oMinute1, oSecond10, oSecond1,
    output hour10, hour1, minute10, minute1, second10, second1,
    output complete, busy, clamped
  );
endinterface

// File: rtl/auto_setting_param.sv
// Keypad time-setting engine: loads BCD hh:mm:ss, adds per-key steps with carry
// normalisation and hour wrap, presents the result on registered BCD outputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for en
// S_LOAD  | capture current time with per-digit clamping
// S_ARMED | waiting for key/sharp press edge
// S_ADD   | add selected step to sec/min/hour fields
// S_NRM_S | seconds carry into minutes
// S_NRM_M | minutes carry into hours
// S_NRM_H | hour wrap past HOUR_MAX
// S_DONE  | one-cycle complete pulse
module auto_setting_param #(
  parameter int HOUR_MAX = 23,
  parameter int STEP1_S  = 5,
  parameter int STEP2_S  = 10,
  parameter int STEP3_S  = 60
) (
  input logic                 clock,
  input logic                 reset,
  auto_setting_param_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARMED, S_ADD, S_NRM_S, S_NRM_M, S_NRM_H, S_DONE
  } state_t;

  localparam logic [6:0] HMAX  = 7'(HOUR_MAX);
  localparam logic [6:0] HWRAP = 7'(HOUR_MAX + 1);
  localparam logic [6:0] ST1_S = 7'(STEP1_S % 60);
  localparam logic [6:0] ST1_M = 7'((STEP1_S / 60) % 60);
  localparam logic [6:0] ST1_H = 7'(STEP1_S / 3600);
  localparam logic [6:0] ST2_S = 7'(STEP2_S % 60);
  localparam logic [6:0] ST2_M = 7'((STEP2_S / 60) % 60);
  localparam logic [6:0] ST2_H = 7'(STEP2_S / 3600);
  localparam logic [6:0] ST3_S = 7'(STEP3_S % 60);
  localparam logic [6:0] ST3_M = 7'((STEP3_S / 60) % 60);
  localparam logic [6:0] ST3_H = 7'(STEP3_S / 3600);

  function automatic logic [3:0] clamp_dig(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    logic [6:0] t;
    t = v / 7'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    logic [6:0] t;
    t = v % 7'd10;
    return t[3:0];
  endfunction

  state_t     state_q, state_d;
  logic [6:0] sec_q, min_q, hour_q;
  logic [6:0] sec_d, min_d, hour_d;
  logic [1:0] key_sel_q, key_sel_d;
  logic [9:0] key_prev_q;
  logic       sharp_prev_q;
  logic       clamp_d;
  logic [3:0] hour10_q, hour1_q, minute10_q, minute1_q, second10_q, second1_q;
  logic       complete_q, busy_q, clamped_q;

  // Press edge only: a clean one-hot word after an all-released cycle; keys 4..9 never act.
  logic       key_fresh;
  logic [3:0] key_ev;
  logic       sharp_ev;
  assign key_fresh = (key_prev_q == 10'd0) && $onehot(bus.keypad);
  assign key_ev    = key_fresh ? bus.keypad[3:0] : 4'd0;
  assign sharp_ev  = bus.sharp && !sharp_prev_q;

  logic [3:0] ld_h10, ld_h1, ld_m10, ld_m1, ld_s10, ld_s1;
  logic [6:0] hour_raw, hour_ld, min_ld, sec_ld;
  logic       any_clamp;

  always_comb begin
    ld_h10    = clamp_dig(bus.oHour10, 4'd9);
    ld_h1     = clamp_dig(bus.oHour1, 4'd9);
    ld_m10    = clamp_dig(bus.oMinute10, 4'd5);
    ld_m1     = clamp_dig(bus.oMinute1, 4'd9);
    ld_s10    = clamp_dig(bus.oSecond10, 4'd5);
    ld_s1     = clamp_dig(bus.oSecond1, 4'd9);
    hour_raw  = 7'(ld_h10) * 7'd10 + 7'(ld_h1);
    hour_ld   = (hour_raw > HMAX) ? HMAX : hour_raw;
    min_ld    = 7'(ld_m10) * 7'd10 + 7'(ld_m1);
    sec_ld    = 7'(ld_s10) * 7'd10 + 7'(ld_s1);
    any_clamp = (ld_h10 != bus.oHour10) || (ld_h1 != bus.oHour1) ||
                (ld_m10 != bus.oMinute10) || (ld_m1 != bus.oMinute1) ||
                (ld_s10 != bus.oSecond10) || (ld_s1 != bus.oSecond1) ||
                (hour_ld != hour_raw);
  end

  logic [6:0] step_s, step_m, step_h;

  always_comb begin
    step_s = ST1_S;
    step_m = ST1_M;
    step_h = ST1_H;
    case (key_sel_q)
      2'd2: begin step_s = ST2_S; step_m = ST2_M; step_h = ST2_H; end
      2'd3: begin step_s = ST3_S; step_m = ST3_M; step_h = ST3_H; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    key_sel_d = key_sel_q;
    clamp_d   = 1'b0;
    case (state_q)
      S_IDLE: if (bus.en) state_d = S_LOAD;
      S_LOAD: begin
        if (!bus.en) state_d = S_IDLE;
        else begin
          sec_d   = sec_ld;
          min_d   = min_ld;
          hour_d  = hour_ld;
          clamp_d = any_clamp;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!bus.en) state_d = S_IDLE;
        else if (sharp_ev) state_d = S_DONE;
        else if (key_ev[0]) begin
          sec_d  = 7'd0;
          min_d  = 7'd0;
          hour_d = 7'd0;
        end
        else if (key_ev[1]) begin key_sel_d = 2'd1; state_d = S_ADD; end
        else if (key_ev[2]) begin key_sel_d = 2'd2; state_d = S_ADD; end
        else if (key_ev[3]) begin key_sel_d = 2'd3; state_d = S_ADD; end
      end
      S_ADD: begin
        if (!bus.en) state_d = S_IDLE;
        else begin
          sec_d   = sec_q + step_s;
          min_d   = min_q + step_m;
          hour_d  = hour_q + step_h;
          state_d = S_NRM_S;
        end
      end
      S_NRM_S: begin
        if (!bus.en) state_d = S_IDLE;
        else begin
          if (sec_q >= 7'd60) begin
            sec_d = sec_q - 7'd60;
            min_d = min_q + 7'd1;
          end
          state_d = S_NRM_M;
        end
      end
      S_NRM_M: begin
        if (!bus.en) state_d = S_IDLE;
        else begin
          if (min_q >= 7'd60) begin
            min_d  = min_q - 7'd60;
            hour_d = hour_q + 7'd1;
          end
          state_d = S_NRM_H;
        end
      end
      S_NRM_H: begin
        if (!bus.en) state_d = S_IDLE;
        else begin
          if (hour_q > HMAX) hour_d = hour_q - HWRAP;
          state_d = S_ARMED;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      sec_q        <= 7'd0;
      min_q        <= 7'd0;
      hour_q       <= 7'd0;
      key_sel_q    <= 2'd1;
      key_prev_q   <= 10'd0;
      sharp_prev_q <= 1'b0;
      hour10_q     <= 4'd0;
      hour1_q      <= 4'd0;
      minute10_q   <= 4'd0;
      minute1_q    <= 4'd0;
      second10_q   <= 4'd0;
      second1_q    <= 4'd0;
      complete_q   <= 1'b0;
      busy_q       <= 1'b0;
      clamped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      key_sel_q    <= key_sel_d;
      key_prev_q   <= bus.keypad;
      sharp_prev_q <= bus.sharp;
      // Encode from the next-state fields so digits land on the same edge as the fields.
      hour10_q     <= bcd_tens(hour_d);
      hour1_q      <= bcd_ones(hour_d);
      minute10_q   <= bcd_tens(min_d);
      minute1_q    <= bcd_ones(min_d);
      second10_q   <= bcd_tens(sec_d);
      second1_q    <= bcd_ones(sec_d);
      complete_q   <= (state_d == S_DONE);
      busy_q       <= (state_d == S_ADD) || (state_d == S_NRM_S) ||
                      (state_d == S_NRM_M) || (state_d == S_NRM_H);
      clamped_q    <= clamp_d;
    end
  end

  assign bus.hour10   = hour10_q;
  assign bus.hour1    = hour1_q;
  assign bus.minute10 = minute10_q;
  assign bus.minute1  = minute1_q;
  assign bus.second10 = second10_q;
  assign bus.second1  = second1_q;
  assign bus.complete = complete_q;
  assign bus.busy     = busy_q;
  assign bus.clamped  = clamped_q;

endmodule

// File: tb/tb_auto_setting_param.sv
// Bench for auto_setting_param: directed keypad scenarios, a seconds-arithmetic model
// checked every cycle, and literal spot checks. A second instance runs in duration mode.
module tb_auto_setting_param;
  localparam int HM = 23;
  localparam int STEPS [4] = '{0, 5, 10, 60};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  auto_setting_param_if ifa();
  auto_setting_param_if ifb();

  assign ifb.en        = ifa.en;
  assign ifb.keypad    = ifa.keypad;
  assign ifb.sharp     = ifa.sharp;
  assign ifb.oHour10   = ifa.oHour10;
  assign ifb.oHour1    = ifa.oHour1;
  assign ifb.oMinute10 = ifa.oMinute10;
  assign ifb.oMinute1  = ifa.oMinute1;
  assign ifb.oSecond10 = ifa.oSecond10;
  assign ifb.oSecond1  = ifa.oSecond1;

  auto_setting_param #(.HOUR_MAX(23), .STEP1_S(5), .STEP2_S(10), .STEP3_S(60))
    dut_a (.clock(clk), .reset(rst_n), .bus(ifa));
  auto_setting_param #(.HOUR_MAX(99), .STEP1_S(5), .STEP2_S(10), .STEP3_S(60))
    dut_b (.clock(clk), .reset(rst_n), .bus(ifb));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pk(input int h, input int m, input int s);
    return ((h / 10) << 20) | ((h % 10) << 16) | ((m / 10) << 12) |
           ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
  endfunction

  function automatic int out_a();
    return int'({8'd0, ifa.hour10, ifa.hour1, ifa.minute10, ifa.minute1,
                 ifa.second10, ifa.second1});
  endfunction

  function automatic int out_b();
    return int'({8'd0, ifb.hour10, ifb.hour1, ifb.minute10, ifb.minute1,
                 ifb.second10, ifb.second1});
  endfunction

  // Model: mode 0 idle, 1 load, 2 armed, 3 adding, 4 done. Time kept as h/m/s integers.
  int  m_mode = 0, m_left = 0, m_h = 0, m_m = 0, m_s = 0, t_h = 0, t_m = 0, t_s = 0;
  bit  m_valid = 1'b1, e_busy = 1'b0, e_complete = 1'b0, e_clamped = 1'b0;
  logic [9:0] m_kprev = 10'd0;
  logic       m_sprev = 1'b0;

  function automatic int dclamp(input int d, input int lim);
    return (d > lim) ? lim : d;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int kev, tot, hr;
    bit sev;
    if (!rst_n) begin
      m_mode = 0; m_left = 0; m_h = 0; m_m = 0; m_s = 0; m_valid = 1'b1;
      e_busy = 1'b0; e_complete = 1'b0; e_clamped = 1'b0;
      m_kprev = 10'd0; m_sprev = 1'b0;
    end else begin
      kev = -1;
      if (m_kprev == 10'd0 && $countones(ifa.keypad) == 1 && ifa.keypad[9:4] == 6'd0)
        for (int i = 0; i < 4; i++) if (ifa.keypad[i]) kev = i;
      sev = ifa.sharp && !m_sprev;
      e_clamped = 1'b0;
      if (m_mode != 4 && !ifa.en) begin
        if (m_mode == 3) m_valid = 1'b0;
        m_mode = 0;
      end else begin
        case (m_mode)
          0: m_mode = 1;
          1: begin
            hr  = 10 * dclamp(int'(ifa.oHour10), 9) + dclamp(int'(ifa.oHour1), 9);
            m_h = (hr > HM) ? HM : hr;
            m_m = 10 * dclamp(int'(ifa.oMinute10), 5) + dclamp(int'(ifa.oMinute1), 9);
            m_s = 10 * dclamp(int'(ifa.oSecond10), 5) + dclamp(int'(ifa.oSecond1), 9);
            e_clamped = (m_h != 10 * int'(ifa.oHour10) + int'(ifa.oHour1)) ||
                        (m_m != 10 * int'(ifa.oMinute10) + int'(ifa.oMinute1)) ||
                        (m_s != 10 * int'(ifa.oSecond10) + int'(ifa.oSecond1)) ||
                        (ifa.oHour1 > 4'd9) || (ifa.oMinute1 > 4'd9) || (ifa.oSecond1 > 4'd9);
            m_valid = 1'b1;
            m_mode = 2;
          end
          2: begin
            if (sev) m_mode = 4;
            else if (kev == 0) begin m_h = 0; m_m = 0; m_s = 0; end
            else if (kev > 0) begin
              tot = m_h * 3600 + m_m * 60 + m_s + STEPS[kev];
              t_s = tot % 60;
              t_m = (tot / 60) % 60;
              t_h = (tot / 3600) % (HM + 1);
              m_left = 4;
              m_mode = 3;
            end
          end
          3: begin
            m_left--;
            if (m_left == 0) begin m_h = t_h; m_m = t_m; m_s = t_s; m_mode = 2; end
          end
          default: m_mode = 0;
        endcase
      end
      e_busy     = (m_mode == 3);
      e_complete = (m_mode == 4);
      m_kprev = ifa.keypad;
      m_sprev = ifa.sharp;
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(ifa.busy), int'(e_busy));
    chk("complete", int'(ifa.complete), int'(e_complete));
    chk("clamped", int'(ifa.clamped), int'(e_clamped));
    if (!e_busy && m_valid) chk("time", out_a(), pk(m_h, m_m, m_s));
  end

  task automatic set_o(input int h10, input int h1, input int m10, input int m1,
                       input int s10, input int s1);
    ifa.oHour10 = 4'(h10); ifa.oHour1 = 4'(h1);
    ifa.oMinute10 = 4'(m10); ifa.oMinute1 = 4'(m1);
    ifa.oSecond10 = 4'(s10); ifa.oSecond1 = 4'(s1);
  endtask

  task automatic press(input int k);
    ifa.keypad = 10'd1 << k;
    @(negedge clk);
    ifa.keypad = 10'd0;
  endtask

  task automatic restart();
    ifa.en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    ifa.en = 1'b0; ifa.keypad = 10'd0; ifa.sharp = 1'b0;
    set_o(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_time", out_a(), 0);
    chk("rst_busy", int'(ifa.busy), 0);
    chk("rst_complete", int'(ifa.complete), 0);
    rst_n = 1'b1;

    // 12:34:56 + 5 s
    set_o(1, 2, 3, 4, 5, 6); ifa.en = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_loaded", out_a(), pk(12, 34, 56));
    press(1);
    chk("t1_busy_c1", int'(ifa.busy), 1);
    repeat (3) @(negedge clk);
    chk("t1_busy_c4", int'(ifa.busy), 1);
    @(negedge clk);
    chk("t1_result", out_a(), pk(12, 35, 1));
    chk("t1_idle_busy", int'(ifa.busy), 0);

    // 23:59:59 + 60 s wraps in 24 h mode, rolls to 24 in duration mode
    restart();
    set_o(2, 3, 5, 9, 5, 9); ifa.en = 1'b1;
    repeat (3) @(negedge clk);
    press(3);
    repeat (4) @(negedge clk);
    chk("t2_wrap23", out_a(), pk(0, 0, 59));
    chk("t2_wrap99", out_b(), pk(24, 0, 59));

    // illegal digits 1F:7A:99
    restart();
    set_o(1, 15, 7, 10, 9, 9); ifa.en = 1'b1;
    repeat (2) @(negedge clk);
    chk("t3_clamped_pulse", int'(ifa.clamped), 1);
    chk("t3_value", out_a(), pk(19, 59, 59));
    @(negedge clk);
    chk("t3_clamped_drop", int'(ifa.clamped), 0);

    // held key2 adds once; key1 during busy is dropped
    ifa.keypad = 10'd4;
    repeat (20) @(negedge clk);
    ifa.keypad = 10'd0;
    repeat (2) @(negedge clk);
    chk("t4_hold_once", out_a(), pk(20, 0, 9));
    press(2);
    ifa.keypad = 10'd2;
    @(negedge clk);
    ifa.keypad = 10'd0;
    repeat (4) @(negedge clk);
    chk("t4_drop_busy", out_a(), pk(20, 0, 19));
    chk("t4_not_busy", int'(ifa.busy), 0);

    // ignored keys, clear, confirm
    restart();
    set_o(0, 8, 0, 0, 0, 0); ifa.en = 1'b1;
    repeat (3) @(negedge clk);
    press(4);
    @(negedge clk);
    ifa.keypad = 10'd6;
    @(negedge clk);
    ifa.keypad = 10'd0;
    repeat (5) @(negedge clk);
    chk("t5_ignored", out_a(), pk(8, 0, 0));
    press(0);
    chk("t5_clear", out_a(), 0);
    ifa.sharp = 1'b1;
    @(negedge clk);
    chk("t5_complete", int'(ifa.complete), 1);
    ifa.sharp = 1'b0; ifa.en = 1'b0;
    @(negedge clk);
    chk("t5_complete_1clk", int'(ifa.complete), 0);
    chk("t5_hold_value", out_a(), 0);

    // en drop during minute normalisation aborts
    ifa.en = 1'b1;
    repeat (3) @(negedge clk);
    press(1);
    repeat (2) @(negedge clk);
    ifa.en = 1'b0;
    @(negedge clk);
    chk("t6_abort_busy", int'(ifa.busy), 0);
    repeat (3) @(negedge clk);
    chk("t6_no_complete", int'(ifa.complete), 0);

    // reset during ADD
    ifa.en = 1'b1;
    repeat (3) @(negedge clk);
    press(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_time", out_a(), 0);
    chk("t6_rst_busy", int'(ifa.busy), 0);
    chk("t6_rst_time_b", out_b(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ifa.en = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_after_rst", int'(ifa.complete), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
